wb_frame_tx: RTL
================

Name: wb_frame_tx

Overview:
Wishbone classic responder that accepts configuration writes from a bus initiator and turns them into serial frames. Each frame is a one-bit-period sync pulse on ena_o followed by a 10-bit payload, LSB first, on data_o. It is the responder side of the write sequence the test bench drives, and the source of the ena_o/data_o stream the bench captures.

Parameters:
FRAME_W, 10, payload bits per frame
DIV_W, 8, width of bit-period divider field
CNT_W, 8, width of frame-count field

Ports:
CLK_I  in  1  system clock
RST_I  in  1  asynchronous, active-high reset
CYC_I  in  1  bus cycle valid
STB_I  in  1  strobe
WE_I  in  1  1 = write, 0 = read
ADR_I  in  32  byte address; only ADR_I[3:2] decoded
DAT_I  in  32  write data
DAT_O  out  32  read data, valid while ACK_O=1
ACK_O  out  1  transfer acknowledge
ena_o  out  1  frame sync, high for one bit period per frame
data_o  out  1  serial payload, LSB first
busy_o  out  1  frame sequence in progress

Behaviour:
- Reset: one clock; RST_I is asynchronous and active-high.
- Reset values: ACK_O=0, DAT_O=0, ena_o=0, data_o=0, busy_o=0, all registers 0, FSM=IDLE.
- RST_I asserted mid-frame aborts immediately to the reset state.
- Bus request: CYC_I&STB_I.
- ACK_O rises one clock after the request is first seen and lasts exactly one clock.
- A new ACK needs STB_I low for at least one clock. Holding STB_I high never re-acks and never re-writes.
- Writes take effect on the ACK clock. DAT_O is registered with ACK_O.
- Register map (ADR_I[3:2]):
  0 CTRL (rw): [0] START (write-only, reads 0, self-clearing); [15:8] DIV (bit period in clocks; 0 treated as 1); [23:16] NFRAMES.
  1 DATA (rw): [9:0] base payload; upper bits read 0.
  2 STATUS (ro): [0] busy; [15:8] frames sent since last START.
  3 reserved: reads 0, writes ignored, still ACKed.
- CTRL write while busy_o=1: the whole write is ignored (DIV, NFRAMES and START), and the write is still ACKed.
- START=1 with NFRAMES=0: DIV/NFRAMES are stored, no sequence starts.
- START=1 with NFRAMES>0 and idle: busy_o=1 on the next clock, frame counter and sent count cleared.
- FSM states:
  IDLE: ena_o=0, data_o=0. Leaves on a valid START to SYNC.
  SYNC: ena_o=1 for DIV clocks, then DATA.
  DATA: ena_o=0. data_o=payload[bit] for DIV clocks per bit, bit 0..9. After bit 9, go to GAP.
  GAP: ena_o=0, data_o=0 for DIV clocks. Increment sent count. If sent==NFRAMES go to IDLE and clear busy_o, else go to SYNC.
- Payload of frame k (k from 0): (DATA[9:0]+k) mod 1024, latched at entry to SYNC. A DATA write mid-frame affects only later frames.
- Frame length = 12*DIV clocks. A sequence of N frames lasts N*12*DIV clocks.
- Sent count wraps mod 256 (only reachable if NFRAMES logic is misused). NFRAMES=255 is legal.

Decomposition:
- Package wb_frame_pkg: register offsets (CTRL/DATA/STATUS), CTRL field bit positions, and FSM state enum {IDLE, SYNC, DATA, GAP}.
- One sub-module: wb_frame_regs (Wishbone decode, ACK generation, register file). The top holds the FSM, divider counter, bit counter and frame counter.

Test Plan:
- Reset release, no bus activity for 200 clocks -> ACK_O, ena_o, data_o, busy_o all stay 0.
- Write DATA=0x0A5, then CTRL=0x00030201 (DIV=2, NFRAMES=3, START), STB held 5+ clocks -> exactly one ACK per write. Three frames with payloads 0x0A5, 0x0A6, 0x0A7, each 24 clocks long. busy_o high for 72 clocks. STATUS reads 0x00000300 afterwards.
- Two back-to-back CTRL=0x00030201 writes, second issued mid-sequence -> second is ACKed but ignored, still 3 frames total. A repeat write after idle starts a new 3-frame sequence.
- DIV=0, NFRAMES=1, DATA=0x3FF -> ena_o high 1 clock, then ten 1-clock bits all 1, busy_o drops after 12 clocks.
- Read addresses 0x0, 0x4, 0xC -> CTRL returns the stored value with bit0=0, DATA returns [9:0] only, 0xC returns 0. Each read ACKed once.
- RST_I pulsed during DATA state of frame 2 -> outputs return to 0 asynchronously, and a STATUS read afterwards returns 0.

Source files
------------

// File: rtl/wb_frame_pkg.sv
// -----------------------------------------------------------------------------
// wb_frame_pkg
// Shared definitions for the Wishbone frame transmitter: register offsets
// (word index taken from ADR_I[3:2]), CTRL/STATUS field positions and the
// frame sequencer state encoding.
// -----------------------------------------------------------------------------
package wb_frame_pkg;

    // Register word offsets (ADR_I[3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // CTRL field positions
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DIV_LSB   = 8;
    localparam int CTRL_NFR_LSB   = 16;

    // STATUS field positions
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_SENT_LSB  = 8;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage : wb_frame_pkg

// File: rtl/wb_frame_regs.sv
// -----------------------------------------------------------------------------
// wb_frame_regs
// Wishbone classic responder and register file for wb_frame_tx.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   cyc_i, stb_i      bus request (cyc_i & stb_i)
//   we_i              1 = write
//   adr_i             register word index (ADR_I[3:2])
//   dat_i / dat_o     write data / registered read data (valid with ack_o)
//   ack_o             single-cycle acknowledge
//   busy_i, sent_i    sequencer status, reflected in STATUS
//   div_o, nframes_o  stored CTRL fields
//   base_o            stored base payload
//   start_o           one-cycle pulse: accepted START with NFRAMES > 0
// -----------------------------------------------------------------------------
module wb_frame_regs #(
    parameter int FRAME_W = 10,
    parameter int DIV_W   = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cyc_i,
    input  logic               stb_i,
    input  logic               we_i,
    input  logic [1:0]         adr_i,
    input  logic [31:0]        dat_i,
    output logic [31:0]        dat_o,
    output logic               ack_o,
    input  logic               busy_i,
    input  logic [CNT_W-1:0]   sent_i,
    output logic [DIV_W-1:0]   div_o,
    output logic [CNT_W-1:0]   nframes_o,
    output logic [FRAME_W-1:0] base_o,
    output logic               start_o
);
    import wb_frame_pkg::*;

    logic               req;
    logic               take;
    logic [31:0]        rdata;

    logic               ack_q,   ack_d;
    logic               done_q,  done_d;
    logic [31:0]        dat_q,   dat_d;
    logic [DIV_W-1:0]   div_q,   div_d;
    logic [CNT_W-1:0]   nfr_q,   nfr_d;
    logic [FRAME_W-1:0] base_q,  base_d;
    logic               start_q, start_d;

    logic               unused_dat;
    assign unused_dat = ^dat_i[31:24];

    assign req = cyc_i & stb_i;
    // done_q remembers that the current strobe has already been served, so a
    // held strobe is acknowledged (and written) exactly once.
    assign take = req & ~done_q;

    always_comb begin
        rdata = '0;
        case (adr_i)
            REG_CTRL: begin
                rdata[CTRL_DIV_LSB +: DIV_W] = div_q;
                rdata[CTRL_NFR_LSB +: CNT_W] = nfr_q;
            end
            REG_DATA:   rdata[FRAME_W-1:0] = base_q;
            REG_STATUS: begin
                rdata[STAT_BUSY_BIT]          = busy_i;
                rdata[STAT_SENT_LSB +: CNT_W] = sent_i;
            end
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        ack_d   = take;
        done_d  = req;
        dat_d   = (take && !we_i) ? rdata : '0;
        div_d   = div_q;
        nfr_d   = nfr_q;
        base_d  = base_q;
        start_d = 1'b0;
        if (take && we_i) begin
            case (adr_i)
                REG_CTRL: begin
                    // start_q covers the single cycle between an accepted
                    // START and the sequencer reporting busy.
                    if (!busy_i && !start_q) begin
                        div_d   = dat_i[CTRL_DIV_LSB +: DIV_W];
                        nfr_d   = dat_i[CTRL_NFR_LSB +: CNT_W];
                        start_d = dat_i[CTRL_START_BIT] &&
                                  (dat_i[CTRL_NFR_LSB +: CNT_W] != '0);
                    end
                end
                REG_DATA: base_d = dat_i[FRAME_W-1:0];
                default:  base_d = base_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            dat_q   <= '0;
            div_q   <= '0;
            nfr_q   <= '0;
            base_q  <= '0;
            start_q <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            done_q  <= done_d;
            dat_q   <= dat_d;
            div_q   <= div_d;
            nfr_q   <= nfr_d;
            base_q  <= base_d;
            start_q <= start_d;
        end
    end

    assign ack_o     = ack_q;
    assign dat_o     = dat_q;
    assign div_o     = div_q;
    assign nframes_o = nfr_q;
    assign base_o    = base_q;
    assign start_o   = start_q;

endmodule : wb_frame_regs

// File: rtl/wb_frame_tx.sv
// -----------------------------------------------------------------------------
// wb_frame_tx
// Wishbone-configured serial frame transmitter. Each frame is a sync pulse of
// one bit period on ena_o, FRAME_W payload bits LSB first on data_o, and one
// idle bit period; frame length is (FRAME_W+2)*DIV clocks.
//
// Ports:
//   CLK_I, RST_I            clock, asynchronous active-high reset
//   CYC_I, STB_I, WE_I      Wishbone classic control
//   ADR_I, DAT_I, DAT_O     address (ADR_I[3:2] decoded), write/read data
//   ACK_O                   single-cycle acknowledge
//   ena_o                   frame sync
//   data_o                  serial payload
//   busy_o                  frame sequence in progress
// -----------------------------------------------------------------------------
module wb_frame_tx #(
    parameter int FRAME_W = 10,
    parameter int DIV_W   = 8,
    parameter int CNT_W   = 8
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        ena_o,
    output logic        data_o,
    output logic        busy_o
);
    import wb_frame_pkg::*;

    localparam int                 BIT_W    = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0]   div;
    logic [CNT_W-1:0]   nframes;
    logic [FRAME_W-1:0] base;
    logic               start;

    state_t             state_q,   state_d;
    logic [DIV_W-1:0]   divcnt_q,  divcnt_d;
    logic [BIT_W-1:0]   bit_q,     bit_d;
    logic [CNT_W-1:0]   sent_q,    sent_d;
    logic [FRAME_W-1:0] payload_q, payload_d;

    logic [DIV_W-1:0]   div_eff;
    logic               period_end;

    logic               unused_adr;
    assign unused_adr = ^{ADR_I[31:4], ADR_I[1:0]};

    wb_frame_regs #(
        .FRAME_W (FRAME_W),
        .DIV_W   (DIV_W),
        .CNT_W   (CNT_W)
    ) u_regs (
        .clk_i     (CLK_I),
        .rst_i     (RST_I),
        .cyc_i     (CYC_I),
        .stb_i     (STB_I),
        .we_i      (WE_I),
        .adr_i     (ADR_I[3:2]),
        .dat_i     (DAT_I),
        .dat_o     (DAT_O),
        .ack_o     (ACK_O),
        .busy_i    (busy_o),
        .sent_i    (sent_q),
        .div_o     (div),
        .nframes_o (nframes),
        .base_o    (base),
        .start_o   (start)
    );

    // A divider of 0 behaves as 1 so the sequencer always advances.
    assign div_eff    = (div == '0) ? DIV_ONE : div;
    assign period_end = (divcnt_q == div_eff - DIV_ONE);

    assign busy_o = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        divcnt_d  = divcnt_q;
        bit_d     = bit_q;
        sent_d    = sent_q;
        payload_d = payload_q;
        ena_o     = 1'b0;
        data_o    = 1'b0;

        if (state_q != IDLE) begin
            divcnt_d = period_end ? '0 : divcnt_q + DIV_ONE;
        end

        case (state_q)
            IDLE: begin
                divcnt_d = '0;
                if (start) begin
                    state_d   = SYNC;
                    bit_d     = '0;
                    sent_d    = '0;
                    payload_d = base;
                end
            end
            SYNC: begin
                ena_o = 1'b1;
                if (period_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                data_o = payload_q[bit_q];
                if (period_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = GAP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (period_end) begin
                    sent_d = sent_q + 1'b1;
                    if (sent_d == nframes) begin
                        state_d = IDLE;
                    end else begin
                        // Frame k carries base + k, sampled as the frame begins.
                        state_d   = SYNC;
                        payload_d = base + FRAME_W'(sent_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= IDLE;
            divcnt_q  <= '0;
            bit_q     <= '0;
            sent_q    <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            divcnt_q  <= divcnt_d;
            bit_q     <= bit_d;
            sent_q    <= sent_d;
            payload_q <= payload_d;
        end
    end

endmodule : wb_frame_tx
